wb_daq_master_writer: RTL
=========================

# wb_daq_master_writer

Wishbone B3 classic master that drains acquired DAQ samples into system memory. It sits between a DAQ channel's sample source and the system bus. It is the bus initiator complementing the DAQ slave register block: that block's channel address/control outputs drive `start_address`, `transfer_length` and `start`, and this block's status outputs feed that block's channel status input. Samples are buffered in a small FIFO. Each sample is written as one single-beat classic cycle to consecutive word addresses.

## Interface
Parameters:
- `dw`, 32: data width; must be 32.
- `aw`, 32: Wishbone address width (byte address).
- `FIFO_AW`, 2: log2 of sample FIFO depth (default depth 4).
- `RETRY_MAX`, 3: number of `wb_rty_i` responses tolerated per word before the block aborts.

Ports:
- `wb_clk` in 1: the only clock. Everything in the block is registered on its rising edge.
- `wb_rst` in 1: reset. Synchronous and active-high; every register returns to its reset value on the next `wb_clk` edge while it is high.
- `start` in 1: one-cycle pulse that begins a run. Ignored while `busy`=1.
- `start_address` in aw: byte address of the first word of the run. Sampled only when `start` is accepted.
- `transfer_length` in 16: number of words in the run. Sampled only when `start` is accepted.
- `sample_valid` in 1: sample presented.
- `sample_data` in dw: sample word.
- `sample_ready` out 1: the FIFO is not full. A sample is pushed when `sample_valid` & `sample_ready`.
- `wb_adr_o` out aw, `wb_dat_o` out dw, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_cti_o` out 3, `wb_bte_o` out 2: master request outputs, all registered.
- `wb_dat_i` in dw: read data. Unused; this block only writes.
- `wb_ack_i` in 1, `wb_err_i` in 1, `wb_rty_i` in 1: slave responses.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run completes successfully.
- `error` out 1: sticky abort flag. Cleared by an accepted `start`.
- `words_written` out 16: number of words acknowledged in the current run.

## Operation
- Reset values:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` = 0.
  - `wb_adr_o`, `wb_dat_o` = 0.
  - `wb_sel_o` = 4'hF; `wb_cti_o` = 3'b000; `wb_bte_o` = 2'b00. These three are constant after reset.
  - `busy`, `done`, `error` = 0; `words_written` = 0.
  - FIFO empty, so `sample_ready` = 1.
  - State = IDLE.
- The FIFO accepts samples in every state except ERROR. A push and a pop in the same cycle are both honoured. Contents are preserved across `start`.
- States:
  - **IDLE:** on an accepted `start`, latch address and length, clear `words_written` and `error`, and set `busy`. If length = 0, go to IDLE with `done` pulsed on the next cycle and no bus cycle issued. Otherwise go to GAP.
  - **GAP:** `wb_cyc_o`/`wb_stb_o` low. If the FIFO is non-empty, load `wb_adr_o` = current address and `wb_dat_o` = FIFO head, set cyc/stb/we = 1, and go to WRITE. Otherwise stay in GAP.
  - **WRITE:** hold all request outputs stable until a response arrives. Response priority is err > rty > ack when several are asserted together.
    - On ack: pop the FIFO, add 4 to the address (modulo 2^aw), increment `words_written`, drop cyc/stb/we, and clear the retry counter. If `words_written`+1 equals the latched length, go to IDLE with `busy`=0 and `done` pulsed. Otherwise go to GAP.
    - On rty: drop cyc/stb and increment the retry counter. If the counter already equals RETRY_MAX, go to ERROR. Otherwise go to GAP; the same FIFO head and address are reissued.
    - On err: go to ERROR.
  - **ERROR:** cyc/stb/we = 0, `busy` = 0, `error` = 1, FIFO flushed, `sample_ready` = 0. Leave to IDLE on an accepted `start`; that same start is processed as if accepted in IDLE.
- After every response, cyc/stb are low for at least one cycle (the GAP state). This prevents a registered-ack slave from acknowledging the same access twice.

## Timing
- Registered-ack slave: `wb_stb_o` rises at cycle t, `wb_ack_i` arrives at t+1, stb is low at t+2, and the next stb rises at t+3. Throughput is therefore 3 cycles per word.
- `start` at cycle s with a non-empty FIFO gives `busy`=1 at s+1, GAP at s+1, and the first stb at s+2.
- `done` rises in the cycle after the final ack edge, together with `busy`=0. It is high for exactly one cycle.
- `words_written` updates on the ack edge.
- `sample_ready` is combinational from the FIFO count; it is low only when the FIFO is full or the state is ERROR.
- `wb_rst` asserted mid-cycle drops cyc/stb on the next edge and discards the FIFO and the run. An ack arriving in that same cycle is ignored.

## Test plan
- Reset: after the reset edge, all outputs equal their listed reset values and `sample_ready`=1.
- Run of 3 words: preload 0x11, 0x22, 0x33, then start with address 0x1000 and length 3 against a registered-ack slave. Required: writes of 0x11@0x1000, 0x22@0x1004, 0x33@0x1008 with stb spacing of 3 cycles; `done` pulses once; `words_written`=3.
- Backpressure: a slave delaying ack by 5 cycles keeps adr/dat/stb stable throughout. Pushing 5 samples makes `sample_ready` go low after the 4th push.
- Retry: the slave answers rty twice and then acks. The same address and data are reissued each time, and `words_written` increments once. With RETRY_MAX=3 and a fourth rty, the block reaches ERROR with `error`=1 and `busy`=0.
- Error: err on word 2 of 4 gives ERROR, the FIFO is flushed, and `words_written`=1. A new start clears `error` and begins at the new address.
- Edge cases:
  - Length 0 pulses `done` with no cyc.
  - `start` while busy is ignored.
  - Address 0xFFFFFFFC wraps to 0x00000000.

Source files
------------

// File: rtl/wb_daq_master_writer.sv
// wb_daq_master_writer: Wishbone B3 classic master that drains a small sample FIFO
// into consecutive memory words, one single-beat write per sample.
module wb_daq_master_writer #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int FIFO_AW   = 2,
  parameter int RETRY_MAX = 3
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          start,
  input  logic [aw-1:0] start_address,
  input  logic [15:0]   transfer_length,
  input  logic          sample_valid,
  input  logic [dw-1:0] sample_data,
  output logic          sample_ready,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_written
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int RW = $clog2(RETRY_MAX + 2);
  typedef enum logic [1:0] {IDLE, GAP, WRITE, ERROR} state_t;
  state_t state;
  logic [dw-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] cnt;
  logic [aw-1:0] addr;
  logic [15:0] len;
  logic [RW-1:0] rty_cnt;
  logic push, pop, unused_dat;
  assign unused_dat = ^wb_dat_i;
  assign wb_sel_o = 4'hF;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  assign sample_ready = cnt != (FIFO_AW + 1)'(DEPTH) && state != ERROR;
  assign push = sample_valid && sample_ready;
  assign pop = state == WRITE && wb_ack_i && !wb_err_i && !wb_rty_i;
  always_ff @(posedge wb_clk)
    if (push) mem[wp] <= sample_data;
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (state == ERROR) begin
      rp <= wp;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end
  end
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
      {wb_cyc_o, wb_stb_o, wb_we_o} <= 3'b000;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      {busy, done, error} <= 3'b000;
      words_written <= '0;
      addr <= '0;
      len <= '0;
      rty_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, ERROR: if (start) begin
          addr <= start_address;
          len <= transfer_length;
          words_written <= '0;
          error <= 1'b0;
          rty_cnt <= '0;
          busy <= transfer_length != 16'd0;
          done <= transfer_length == 16'd0;
          state <= transfer_length == 16'd0 ? IDLE : GAP;
        end
        GAP: if (cnt != '0) begin
          wb_adr_o <= addr;
          wb_dat_o <= mem[rp];
          {wb_cyc_o, wb_stb_o, wb_we_o} <= 3'b111;
          state <= WRITE;
        end
        WRITE: if (wb_err_i || wb_rty_i || wb_ack_i) begin
          {wb_cyc_o, wb_stb_o, wb_we_o} <= 3'b000;
          if (wb_err_i || (wb_rty_i && rty_cnt == RW'(RETRY_MAX))) begin
            state <= ERROR;
            busy <= 1'b0;
            error <= 1'b1;
          end else if (wb_rty_i) begin
            rty_cnt <= rty_cnt + 1'b1;
            state <= GAP;
          end else begin
            addr <= addr + aw'(4);
            words_written <= words_written + 16'd1;
            rty_cnt <= '0;
            busy <= words_written + 16'd1 != len;
            done <= words_written + 16'd1 == len;
            state <= words_written + 16'd1 == len ? IDLE : GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
